// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding and memory access width codes
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;
    localparam logic [1:0] WIDTH_B = 2'd0;
    localparam logic [1:0] WIDTH_H = 2'd1;
    localparam logic [1:0] WIDTH_W = 2'd2;
    localparam int STARVE_BITS = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and memory-side signals of the arbiter
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_data;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_write;
    logic [31:0] d_wdata;
    logic        d_extend;
    logic [1:0]  d_width;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        req;
    logic [31:0] addr;
    logic        write;
    logic [31:0] data_out;
    logic        extend;
    logic [1:0]  width;
    logic        ack;
    logic [31:0] data_in;
    modport master (
        input  i_req, i_addr, d_req, d_addr, d_write, d_wdata, d_extend, d_width, ack, data_in,
        output i_ack, i_data, d_ack, d_rdata, req, addr, write, data_out, extend, width
    );
    modport slave (
        output i_req, i_addr, d_req, d_addr, d_write, d_wdata, d_extend, d_width, ack, data_in,
        input  i_ack, i_data, d_ack, d_rdata, req, addr, write, data_out, extend, width
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters,
// one transaction at a time, with starvation protection for fetch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.master bus
);
    localparam logic [STARVE_BITS-1:0] STARVE_LIM = STARVE_BITS'(STARVE_MAX);
    state_t                 r_state;
    logic [STARVE_BITS-1:0] r_starve;
    logic                   w_d_win;
    assign w_d_win     = bus.d_req & (~bus.i_req | (r_starve < STARVE_LIM));
    assign bus.i_data  = bus.data_in;
    assign bus.d_rdata = bus.data_in;
    assign bus.i_ack   = bus.ack & (r_state == BUSY_I) & bus.i_req;
    assign bus.d_ack   = bus.ack & (r_state == BUSY_D) & bus.d_req;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_starve     <= '0;
            bus.req      <= 1'b0;
            bus.addr     <= '0;
            bus.write    <= 1'b0;
            bus.data_out <= '0;
            bus.extend   <= 1'b0;
            bus.width    <= '0;
        end else if (r_state == IDLE) begin
            if (w_d_win) begin
                r_state      <= BUSY_D;
                bus.req      <= 1'b1;
                bus.addr     <= bus.d_addr;
                bus.write    <= bus.d_write;
                bus.data_out <= bus.d_wdata;
                bus.extend   <= bus.d_extend;
                bus.width    <= bus.d_width;
                // data only beats a waiting fetch below the limit, so this tops out at STARVE_MAX
                r_starve     <= bus.i_req ? r_starve + 1'b1 : '0;
            end else if (bus.i_req) begin
                r_state      <= BUSY_I;
                bus.req      <= 1'b1;
                bus.addr     <= bus.i_addr;
                bus.write    <= 1'b0;
                bus.data_out <= '0;
                bus.extend   <= 1'b0;
                bus.width    <= WIDTH_W;
                r_starve     <= '0;
            end
        end else if (bus.ack) begin
            r_state <= IDLE;
            bus.req <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;
    localparam int SM = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    mem_arbiter_if bus();
    mem_arbiter #(.STARVE_MAX(SM)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    int tests = 0;
    int fails = 0;
    int m_own, m_streak;
    logic m_req, m_write, m_ext;
    logic [31:0] m_addr, m_wdata;
    logic [1:0] m_width;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_own = 0; m_streak = 0; m_req = 0; m_addr = 0;
        m_write = 0; m_wdata = 0; m_ext = 0; m_width = 0;
    endtask

    // owner: 0 none, 1 fetch, 2 data; streak counts data wins over a waiting fetch
    task automatic m_edge();
        if (m_own != 0) begin
            if (bus.ack) begin m_own = 0; m_req = 0; end
        end else if (bus.d_req && (!bus.i_req || m_streak < SM)) begin
            m_own = 2; m_req = 1; m_addr = bus.d_addr; m_write = bus.d_write;
            m_wdata = bus.d_wdata; m_ext = bus.d_extend; m_width = bus.d_width;
            m_streak = bus.i_req ? m_streak + 1 : 0;
        end else if (bus.i_req) begin
            m_own = 1; m_req = 1; m_addr = bus.i_addr; m_write = 0;
            m_wdata = 0; m_ext = 0; m_width = WIDTH_W; m_streak = 0;
        end
    endtask

    task automatic check_all();
        chk("req", 32'(bus.req), 32'(m_req));
        chk("addr", bus.addr, m_addr);
        chk("write", 32'(bus.write), 32'(m_write));
        chk("data_out", bus.data_out, m_wdata);
        chk("extend", 32'(bus.extend), 32'(m_ext));
        chk("width", 32'(bus.width), 32'(m_width));
        chk("i_ack", 32'(bus.i_ack), 32'(bus.ack && m_own == 1 && bus.i_req));
        chk("d_ack", 32'(bus.d_ack), 32'(bus.ack && m_own == 2 && bus.d_req));
        chk("i_data", bus.i_data, bus.data_in);
        chk("d_rdata", bus.d_rdata, bus.data_in);
        chk("ack_excl", 32'(bus.i_ack & bus.d_ack), 32'(0));
    endtask

    task automatic step();
        #1 check_all();
        @(posedge clk);
        #1 m_edge();
    endtask

    task automatic drive(logic ir, logic [31:0] ia, logic dr, logic [31:0] da, logic dw,
                         logic [31:0] wd, logic de, logic [1:0] dwid, logic a, logic [31:0] din);
        bus.i_req = ir; bus.i_addr = ia; bus.d_req = dr; bus.d_addr = da; bus.d_write = dw;
        bus.d_wdata = wd; bus.d_extend = de; bus.d_width = dwid; bus.ack = a; bus.data_in = din;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        m_reset();
        #1 reset_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        #2 check_all();
        reset_n = 1'b1;
        // fetch alone, ack two cycles after req
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        step();
        chk("t1_req", 32'(bus.req), 32'(1));
        chk("t1_addr", bus.addr, 32'h100);
        chk("t1_width", 32'(bus.width), 32'(2));
        step();
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001);
        #1 chk("t1_iack", 32'(bus.i_ack), 32'(1));
        chk("t1_idata", bus.i_data, 32'hCAFE_0001);
        chk("t1_dack", 32'(bus.d_ack), 32'(0));
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t1_iack_once", 32'(bus.i_ack), 32'(0));
        step();
        // simultaneous requests, immediate ack: data first, then fetch
        pulse_reset();
        drive(1, 32'h100, 1, 32'h2000, 1, 32'hDEADBEEF, 0, WIDTH_W, 1, 32'h5);
        step();
        chk("t2_addr_d", bus.addr, 32'h2000);
        chk("t2_dout", bus.data_out, 32'hDEADBEEF);
        chk("t2_write", 32'(bus.write), 32'(1));
        drive(1, 32'h100, 0, 32'h2000, 1, 32'hDEADBEEF, 0, WIDTH_W, 1, 32'h5);
        step();
        step();
        chk("t2_addr_i", bus.addr, 32'h100);
        chk("t2_write_i", 32'(bus.write), 32'(0));
        step();
        // starvation: both held, ack always high -> 4 data, 1 fetch, data again
        pulse_reset();
        drive(1, 32'h100, 1, 32'h2000, 0, 32'h1, 0, WIDTH_B, 1, 32'h7);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t3_grant", bus.addr, (k == 4) ? 32'h100 : 32'h2000);
            step();
        end
        // abandoned fetch: req held until ack, no i_ack, then data granted
        pulse_reset();
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 32'h100, 1, 32'h3000, 0, 0, 1, WIDTH_H, 0, 0);
        step();
        step();
        chk("t4_req_held", 32'(bus.req), 32'(1));
        chk("t4_addr_held", bus.addr, 32'h100);
        bus.ack = 1'b1;
        #1 chk("t4_no_iack", 32'(bus.i_ack), 32'(0));
        chk("t4_no_dack", 32'(bus.d_ack), 32'(0));
        step();
        bus.ack = 1'b0;
        step();
        chk("t4_d_grant", bus.addr, 32'h3000);
        chk("t4_d_ext", 32'(bus.extend), 32'(1));
        // reset during BUSY_D clears outputs at once
        pulse_reset();
        drive(0, 0, 1, 32'h4000, 1, 32'h1234, 1, WIDTH_H, 0, 0);
        step();
        chk("t5_req", 32'(bus.req), 32'(1));
        #2 reset_n = 1'b0;
        m_reset();
        #1 chk("t5_rst_req", 32'(bus.req), 32'(0));
        chk("t5_rst_write", 32'(bus.write), 32'(0));
        chk("t5_rst_addr", bus.addr, 32'h0);
        chk("t5_rst_dout", bus.data_out, 32'h0);
        reset_n = 1'b1;
        step();
        chk("t5_regrant", 32'(bus.req), 32'(1));
        // ack in the first req cycle: reissue two cycles after the first req edge
        pulse_reset();
        drive(0, 0, 1, 32'h5000, 0, 0, 0, WIDTH_W, 1, 32'h9);
        step();
        #1 chk("t6_dack", 32'(bus.d_ack), 32'(1));
        step();
        chk("t6_idle", 32'(bus.req), 32'(0));
        step();
        chk("t6_reissue", 32'(bus.req), 32'(1));
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 7, $urandom,
                  1'($urandom), $urandom, 1'($urandom), 2'($urandom_range(0, 2)),
                  $urandom_range(0, 9) < 4, $urandom);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: the fetch stage instruction port (i_*) and the mem stage data port (d_*).
- Sits between both pipeline stages and the memory/bus interface.
- Arbitrates at transaction granularity and registers the winning request onto the memory side.
- Routes ack/data back to the winner only, with starvation protection for fetch.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while fetch is pending before fetch is forced to win (valid range 1..15).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held stable until i_ack
- i_addr  in  32  fetch address (read only, word width)
- i_ack  out  1  fetch transaction complete
- i_data  out  32  fetch read data, valid with i_ack
- d_req  in  1  data request
- d_addr  in  32  data address
- d_write  in  1  data store
- d_wdata  in  32  store data
- d_extend  in  1  sign-extend load
- d_width  in  2  access width
- d_ack  out  1  data transaction complete
- d_rdata  out  32  load data, valid with d_ack
- req  out  1  memory request (registered)
- addr  out  32  memory address (registered)
- write  out  1  memory write (registered)
- data_out  out  32  memory write data (registered)
- extend  out  1  memory extend (registered)
- width  out  2  memory width (registered)
- ack  in  1  memory completion, may assert in the first cycle req is high
- data_in  in  32  memory read data, valid with ack

Behaviour:
- State machine with three states: IDLE, BUSY_I, BUSY_D.
- Reset (async, reset_n=0): state=IDLE, req=0, addr/data_out=0, write=0, extend=0, width=0, starve_cnt=0.
- IDLE transitions:
  - d_req & (~i_req | starve_cnt<STARVE_MAX) -> BUSY_D.
  - Else if i_req -> BUSY_I.
  - Else stay in IDLE.
- On the grant edge, latch the winner's fields into the registered outputs and set req=1.
  - Fetch grant drives write=0, extend=0, width=2'b10, data_out=0.
- Request-to-memory latency: one cycle (requester asserts in cycle N while IDLE, req high in N+1).
- BUSY_x with ack=1:
  - Next state IDLE; req=0 on the next edge.
  - Output fields hold their values (no clear).
- BUSY_x with ack=0: hold all outputs stable.
- Returned data and acks:
  - i_data = d_rdata = data_in (unqualified).
  - i_ack = ack & (state==BUSY_I) & i_req.
  - d_ack = ack & (state==BUSY_D) & d_req.
- A requester that drops its req mid-transaction is abandoned:
  - The memory transaction still completes (req held until ack).
  - No ack is delivered to that requester.
  - The requester's next req waits for IDLE.
  - This is the fetch redirect case.
- Back-to-back: after an ack cycle the arbiter is IDLE for one cycle. A requester still asserting req then is treated as a new request.
  - Minimum throughput: one transaction per 2 cycles.
- starve_cnt (4 bits):
  - Increments on a data grant while i_req=1.
  - Resets to 0 on any fetch grant, or on a data grant with i_req=0.
  - Saturates at STARVE_MAX.
- Simultaneous d_req & i_req with starve_cnt==STARVE_MAX: fetch wins.
- Request arriving while BUSY: no effect until IDLE.
- Reset asserted mid-transaction: req drops immediately (async); the pending transaction is dropped and no ack is delivered.
- req, i_ack, d_ack are never high for both ports at once; i_ack and d_ack are mutually exclusive by construction.

Decomposition:
- Shared package entries:
  - State encoding localparams: IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2.
  - Width encoding constants WIDTH_B=0, WIDTH_H=1, WIDTH_W=2 (shared with mem stage and memory).
- No sub-module is needed. The starvation counter stays inline.

Test Plan:
- Only i_req=1, i_addr=0x100; memory acks 2 cycles after req -> req rises 1 cycle after i_req with addr=0x100, write=0, width=2; i_ack=1 for exactly one cycle with i_data=data_in; d_ack stays 0.
- i_req and d_req rise together (d_addr=0x2000, d_write=1, d_wdata=0xDEADBEEF), immediate ack -> data granted first (addr=0x2000, data_out=0xDEADBEEF); fetch granted on the following arbitration.
- d_req held continuously, i_req held, STARVE_MAX=4, ack same cycle as req -> exactly 4 data transactions, then a fetch transaction, then data resumes.
- Fetch granted, i_req dropped before ack (ack delayed 3 cycles) -> req stays high until ack; i_ack never asserts; the next d_req is granted afterward.
- reset_n pulsed low while BUSY_D with ack=0 -> req, write and all outputs go to 0 immediately (same cycle); after release the arbiter is IDLE and a new d_req is granted with 1-cycle latency.
- ack asserted in the same cycle req first rises -> one-cycle transaction; the arbiter is IDLE the next cycle; a held d_req is reissued 2 cycles after the first req edge.
